// File: rtl/life_grid_stepper.sv
// life_grid_stepper: computes one Game-of-Life style generation from a source map into a
// destination map, one cell at a time, using an external single-bit read/write map interface.
// Each cell takes 9 FETCH cycles (one per 3x3 neighbourhood offset) followed by 1 WRITE cycle.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request one generation (ignored unless idle)
//   rd_x, rd_y         source-map read address (combinational read)
//   rd_data            source cell value for rd_x/rd_y in the same cycle
//   wr_x, wr_y         destination-map write address
//   wr_data, wr_en     destination cell value and write strobe
//   busy, done         generation in progress, one-cycle completion pulse
//   gen_count          number of completed generations (wraps)
//   live_count         live cells written in the last completed generation (saturating)
module life_grid_stepper #(
   parameter int unsigned MAP_W        = 32,
   parameter int unsigned MAP_H        = 32,
   parameter int unsigned WRAP         = 0,
   parameter logic [8:0]  BORN_MASK    = 9'b000001000,
   parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
   localparam int unsigned XW          = $clog2(MAP_W),
   localparam int unsigned YW          = $clog2(MAP_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [XW-1:0] rd_x,
   output logic [YW-1:0] rd_y,
   input  logic          rd_data,
   output logic [XW-1:0] wr_x,
   output logic [YW-1:0] wr_y,
   output logic          wr_data,
   output logic          wr_en,
   output logic          busy,
   output logic          done,
   output logic [15:0]   gen_count,
   output logic [15:0]   live_count
);

   localparam logic [XW-1:0] XMAX = XW'(MAP_W - 1);
   localparam logic [YW-1:0] YMAX = YW'(MAP_H - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    ox_q, ox_d;        // 0,1,2 -> dx = -1,0,+1
   logic [1:0]    oy_q, oy_d;        // 0,1,2 -> dy = -1,0,+1
   logic [3:0]    n_q, n_d;
   logic          centre_q, centre_d;
   logic [15:0]   live_acc_q, live_acc_d;
   logic [15:0]   gen_q, gen_d;
   logic [15:0]   live_q, live_d;

   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          x_off, y_off;
   logic          next_val;

   // Neighbour coordinates. Off-grid offsets (no wrap) leave the coordinate at the edge,
   // which is exactly the clamped in-range address.
   always_comb begin
      nx    = x_q;
      x_off = 1'b0;
      case (ox_q)
         2'd0: begin
            if (x_q == '0) begin
               if (WRAP != 0) nx = XMAX;
               else           x_off = 1'b1;
            end else begin
               nx = x_q - XW'(1);
            end
         end
         2'd2: begin
            if (x_q == XMAX) begin
               if (WRAP != 0) nx = '0;
               else           x_off = 1'b1;
            end else begin
               nx = x_q + XW'(1);
            end
         end
         default: nx = x_q;
      endcase
   end

   always_comb begin
      ny    = y_q;
      y_off = 1'b0;
      case (oy_q)
         2'd0: begin
            if (y_q == '0) begin
               if (WRAP != 0) ny = YMAX;
               else           y_off = 1'b1;
            end else begin
               ny = y_q - YW'(1);
            end
         end
         2'd2: begin
            if (y_q == YMAX) begin
               if (WRAP != 0) ny = '0;
               else           y_off = 1'b1;
            end else begin
               ny = y_q + YW'(1);
            end
         end
         default: ny = y_q;
      endcase
   end

   assign next_val = centre_q ? SURVIVE_MASK[n_q] : BORN_MASK[n_q];

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      ox_d       = ox_q;
      oy_d       = oy_q;
      n_d        = n_q;
      centre_d   = centre_q;
      live_acc_d = live_acc_q;
      gen_d      = gen_q;
      live_d     = live_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StFetch;
               x_d        = '0;
               y_d        = '0;
               ox_d       = 2'd0;
               oy_d       = 2'd0;
               n_d        = 4'd0;
               live_acc_d = 16'd0;
            end
         end
         StFetch: begin
            if (ox_q == 2'd1 && oy_q == 2'd1) begin
               centre_d = rd_data;
            end else if (!x_off && !y_off) begin
               n_d = n_q + {3'b000, rd_data};
            end
            if (ox_q == 2'd2) begin
               ox_d = 2'd0;
               if (oy_q == 2'd2) begin
                  oy_d    = 2'd0;
                  state_d = StWrite;
               end else begin
                  oy_d = oy_q + 2'd1;
               end
            end else begin
               ox_d = ox_q + 2'd1;
            end
         end
         StWrite: begin
            if (next_val && live_acc_q != 16'hFFFF) live_acc_d = live_acc_q + 16'd1;
            n_d     = 4'd0;
            state_d = StFetch;
            if (x_q == XMAX) begin
               x_d = '0;
               if (y_q == YMAX) begin
                  // Publish counters on entry to DONE so they are valid alongside the pulse.
                  state_d = StDone;
                  gen_d   = gen_q + 16'd1;
                  live_d  = live_acc_d;
               end else begin
                  y_d = y_q + YW'(1);
               end
            end else begin
               x_d = x_q + XW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         ox_q       <= 2'd0;
         oy_q       <= 2'd0;
         n_q        <= 4'd0;
         centre_q   <= 1'b0;
         live_acc_q <= 16'd0;
         gen_q      <= 16'd0;
         live_q     <= 16'd0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         n_q        <= n_d;
         centre_q   <= centre_d;
         live_acc_q <= live_acc_d;
         gen_q      <= gen_d;
         live_q     <= live_d;
      end
   end

   // Outputs decode from state so an asynchronous reset clears them immediately.
   assign busy       = (state_q == StFetch) || (state_q == StWrite);
   assign done       = (state_q == StDone);
   assign wr_en      = (state_q == StWrite);
   assign wr_data    = wr_en & next_val;
   assign wr_x       = wr_en ? x_q : '0;
   assign wr_y       = wr_en ? y_q : '0;
   assign rd_x       = (state_q == StFetch) ? nx : '0;
   assign rd_y       = (state_q == StFetch) ? ny : '0;
   assign gen_count  = gen_q;
   assign live_count = live_q;

endmodule

// File: tb/tb_life_grid_stepper.sv
// Bench for life_grid_stepper: three 8x8 instances share one source map
// (A: clipped edges, B: toroidal, C: clipped with born-on-3-or-6 rule).
module tb_life_grid_stepper;

   logic clk = 1'b0;
   logic rst_n, start, clr;
   logic [63:0] src, dst_a, dst_b, dst_c;

   always #5 clk = ~clk;

   logic [2:0]  rd_x_a, rd_y_a, wr_x_a, wr_y_a;
   logic [2:0]  rd_x_b, rd_y_b, wr_x_b, wr_y_b;
   logic [2:0]  rd_x_c, rd_y_c, wr_x_c, wr_y_c;
   logic        rd_data_a, wr_data_a, wr_en_a, busy_a, done_a;
   logic        rd_data_b, wr_data_b, wr_en_b, busy_b, done_b;
   logic        rd_data_c, wr_data_c, wr_en_c, busy_c, done_c;
   logic [15:0] gen_a, live_a, gen_b, live_b, gen_c, live_c;

   assign rd_data_a = src[{rd_y_a, rd_x_a}];
   assign rd_data_b = src[{rd_y_b, rd_x_b}];
   assign rd_data_c = src[{rd_y_c, rd_x_c}];

   always_ff @(posedge clk) begin
      if (clr) begin
         dst_a <= '0;
         dst_b <= '0;
         dst_c <= '0;
      end else begin
         if (wr_en_a) dst_a[{wr_y_a, wr_x_a}] <= wr_data_a;
         if (wr_en_b) dst_b[{wr_y_b, wr_x_b}] <= wr_data_b;
         if (wr_en_c) dst_c[{wr_y_c, wr_x_c}] <= wr_data_c;
      end
   end

   life_grid_stepper #(.MAP_W(8), .MAP_H(8), .WRAP(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_x(rd_x_a), .rd_y(rd_y_a),
      .rd_data(rd_data_a), .wr_x(wr_x_a), .wr_y(wr_y_a), .wr_data(wr_data_a),
      .wr_en(wr_en_a), .busy(busy_a), .done(done_a), .gen_count(gen_a), .live_count(live_a));

   life_grid_stepper #(.MAP_W(8), .MAP_H(8), .WRAP(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_x(rd_x_b), .rd_y(rd_y_b),
      .rd_data(rd_data_b), .wr_x(wr_x_b), .wr_y(wr_y_b), .wr_data(wr_data_b),
      .wr_en(wr_en_b), .busy(busy_b), .done(done_b), .gen_count(gen_b), .live_count(live_b));

   life_grid_stepper #(.MAP_W(8), .MAP_H(8), .WRAP(0), .BORN_MASK(9'b001001000)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_x(rd_x_c), .rd_y(rd_y_c),
      .rd_data(rd_data_c), .wr_x(wr_x_c), .wr_y(wr_y_c), .wr_data(wr_data_c),
      .wr_en(wr_en_c), .busy(busy_c), .done(done_c), .gen_count(gen_c), .live_count(live_c));

   // Map bit index = y*8 + x.
   typedef struct {
      string       name;
      logic [63:0] src;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
      logic [63:0] exp_c;
      logic [15:0] live_a;
      logic [15:0] live_b;
      logic [15:0] live_c;
   } vec_t;

   vec_t vecs[4];
   int   n_vec  = 0;
   int   n_miss = 0;
   logic [15:0] exp_gen;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Runs one generation: a stray start at cycle 50 and another during DONE must be ignored.
   task automatic run_vec(input int idx);
      int busy_cyc, writes, dones, done_at;
      busy_cyc = 0; writes = 0; dones = 0; done_at = -1;
      src = vecs[idx].src;
      clr = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if (busy_a) busy_cyc++;
         if (wr_en_a) writes++;
         if (done_a) begin
            dones++;
            if (done_at < 0) done_at = i;
         end
         start = (i == 49 || i == 640);
         @(negedge clk);
      end
      start = 1'b0;
      exp_gen = exp_gen + 16'd1;
      chk({vecs[idx].name, " busy_cycles"}, 64'(busy_cyc), 64'd640);
      chk({vecs[idx].name, " done_pulses"}, 64'(dones), 64'd1);
      chk({vecs[idx].name, " done_cycle"}, 64'(done_at), 64'd640);
      chk({vecs[idx].name, " writes"}, 64'(writes), 64'd64);
      chk({vecs[idx].name, " map_a"}, dst_a, vecs[idx].exp_a);
      chk({vecs[idx].name, " map_b"}, dst_b, vecs[idx].exp_b);
      chk({vecs[idx].name, " map_c"}, dst_c, vecs[idx].exp_c);
      chk({vecs[idx].name, " live_a"}, 64'(live_a), 64'(vecs[idx].live_a));
      chk({vecs[idx].name, " live_b"}, 64'(live_b), 64'(vecs[idx].live_b));
      chk({vecs[idx].name, " live_c"}, 64'(live_c), 64'(vecs[idx].live_c));
      chk({vecs[idx].name, " gen_a"}, 64'(gen_a), 64'(exp_gen));
      chk({vecs[idx].name, " gen_b"}, 64'(gen_b), 64'(exp_gen));
      chk({vecs[idx].name, " gen_c"}, 64'(gen_c), 64'(exp_gen));
   endtask

   initial begin
      // blinker (4..6,5) -> vertical (5,4..6)
      vecs[0] = '{"blinker", 64'h0000_7000_0000_0000, 64'h0020_2020_0000_0000,
                  64'h0020_2020_0000_0000, 64'h0020_2020_0000_0000, 16'd3, 16'd3, 16'd3};
      // corners (0,0),(7,0),(0,7): clipped dies out, torus forms a block incl. (7,7)
      vecs[1] = '{"edge", 64'h0100_0000_0000_0081, 64'h0,
                  64'h8100_0000_0000_0081, 64'h0, 16'd0, 16'd4, 16'd0};
      // block (2,2)-(3,3) is a still life
      vecs[2] = '{"block", 64'h0000_0000_0C0C_0000, 64'h0000_0000_0C0C_0000,
                  64'h0000_0000_0C0C_0000, 64'h0000_0000_0C0C_0000, 16'd4, 16'd4, 16'd4};
      // rows (2..4,2) and (2..4,4): dead (3,3) has 6 neighbours, born only under rule C
      vecs[3] = '{"rule6", 64'h0000_001C_001C_0000, 64'h0000_0808_0008_0800,
                  64'h0000_0808_0008_0800, 64'h0000_0808_0808_0800, 16'd4, 16'd4, 16'd5};

      rst_n = 1'b0; start = 1'b0; clr = 1'b0; src = '0; exp_gen = 16'd0;
      #1;
      chk("reset busy", 64'(busy_a), 64'd0);
      chk("reset done", 64'(done_a), 64'd0);
      chk("reset wr_en", 64'(wr_en_a), 64'd0);
      chk("reset rd_addr", 64'({rd_y_a, rd_x_a}), 64'd0);
      chk("reset gen", 64'(gen_a), 64'd0);
      chk("reset live", 64'(live_a), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 4; v++) run_vec(v);

      // Reset 100 cycles into a generation: abandoned immediately, no further writes.
      src   = vecs[0].src;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset busy", 64'(busy_a), 64'd0);
      chk("midreset wr_en", 64'(wr_en_a), 64'd0);
      chk("midreset gen", 64'(gen_a), 64'd0);
      chk("midreset rd_addr", 64'({rd_y_b, rd_x_b}), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("inreset wr_en", 64'({wr_en_a, wr_en_b, wr_en_c}), 64'd0);
         chk("inreset done", 64'({done_a, done_b, done_c}), 64'd0);
      end
      rst_n   = 1'b1;
      exp_gen = 16'd0;
      @(negedge clk);
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/life_grid_stepper.md
LIFE_GRID_STEPPER -- requirements
Module: life_grid_stepper

Interface
REQ-001 The block SHALL have parameter MAP_W, default 32, meaning grid width in cells (2..256).
REQ-002 The block SHALL have parameter MAP_H, default 32, meaning grid height in cells (2..256).
REQ-003 The block SHALL have parameter WRAP, default 0, meaning 1 = toroidal edges and 0 = off-grid neighbours read as dead.
REQ-004 The block SHALL have parameter BORN_MASK, default 9'b000001000, meaning bit n set = dead cell with n live neighbours becomes live.
REQ-005 The block SHALL have parameter SURVIVE_MASK, default 9'b000001100, meaning bit n set = live cell with n live neighbours stays live.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-008 Port start, input, 1 bit: request one generation step.
REQ-009 Port rd_x, output, XW = clog2(MAP_W) bits, plus rd_y, output, YW = clog2(MAP_H) bits: source-map read address.
REQ-010 Port rd_data, input, 1 bit: source cell value, combinational read, valid in the same cycle as rd_x/rd_y.
REQ-011 Port wr_x, output, XW bits, plus wr_y, output, YW bits: destination-map write address.
REQ-012 Port wr_data, output, 1 bit, plus wr_en, output, 1 bit: destination cell value and write strobe.
REQ-013 Port busy, output, 1 bit, plus done, output, 1 bit: generation in progress, and 1-cycle completion pulse.
REQ-014 Port gen_count, output, 16 bits, plus live_count, output, 16 bits: completed generations, and live cells written in the last completed generation.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WRITE, DONE; IDLE->FETCH on start=1, with cell pointer (x,y) = (0,0), busy=1.
REQ-016 FETCH SHALL last exactly 9 cycles per cell, offsets ordered dy=-1,0,+1 (outer) and dx=-1,0,+1 (inner), sampling rd_data at each cycle end.
REQ-017 With WRAP=1, neighbour coordinates SHALL wrap modulo MAP_W/MAP_H (e.g. x-1 at x=0 gives MAP_W-1), correct for non-power-of-two sizes.
REQ-018 With WRAP=0, off-grid offsets SHALL still consume their FETCH cycle, count as 0, and drive rd_x/rd_y with the clamped in-range value.
REQ-019 Neighbour count n SHALL be the 4-bit sum of the 8 non-centre samples; next = centre ? SURVIVE_MASK[n] : BORN_MASK[n].
REQ-020 WRITE SHALL last 1 cycle: wr_en=1, wr_x/wr_y = current cell, wr_data = next; wr_en SHALL be 0 in every other cycle.
REQ-021 After WRITE, x SHALL increment; at x=MAP_W-1, x=0 and y increments; after cell (MAP_W-1,MAP_H-1) the FSM SHALL enter DONE.
REQ-022 A generation SHALL take exactly 10*MAP_W*MAP_H cycles from the first FETCH cycle to the last WRITE cycle.
REQ-023 DONE SHALL last 1 cycle with done=1, busy=0, gen_count+1 (wrapping 0xFFFF->0), live_count latched from the per-generation counter; then IDLE.
REQ-024 The per-generation live counter SHALL clear on entry to FETCH from IDLE and saturate at 0xFFFF.
REQ-025 start SHALL be ignored while busy=1 or in DONE, with no queuing.
REQ-026 The block SHALL not retain any cell values across cells; it SHALL re-read all 9 cells for every cell.

Reset
REQ-027 On rst_n=0, the block SHALL immediately go to IDLE, with busy, done, wr_en, wr_data, rd_x, rd_y, wr_x, wr_y, gen_count and live_count = 0.
REQ-028 On reset mid-generation, the partial generation SHALL be abandoned, with no further writes and no done pulse.

Verification
REQ-029 Blinker: MAP 8x8, WRAP=0, live (4,5),(5,5),(6,5), start -> after 640 cycles done=1; destination live exactly (5,4),(5,5),(5,6); live_count=3; gen_count=1.
REQ-030 Edge wrap: 8x8, live (0,0),(7,0),(0,7); WRAP=1 -> (7,7) written 1; WRAP=0 -> (7,7) written 0, and no rd_x/rd_y ever exceeds 7.
REQ-031 Block still life: 2x2 live at (2,2)-(3,3), default masks -> destination identical to source, live_count=4.
REQ-032 Rule override: BORN_MASK=9'b001001000, a dead cell with exactly 6 live neighbours -> written 1; with default masks -> written 0.
REQ-033 Handshake: start pulsed again at cycle 50 of a generation -> ignored, exactly one done pulse, gen_count increments by 1 only.
REQ-034 Reset mid-frame: rst_n low at cycle 100 -> same-cycle busy=0, wr_en=0, gen_count=0; then start -> full 640-cycle generation completes correctly.
